dot_prod_vec_loader: RTL and testbench

DOT_PROD_VEC_LOADER -- requirements
Module: dot_prod_vec_loader

---
 rtl/dot_prod_vec_loader.sv | 62 ++++++
 tb/tb_dot_prod_vec_loader.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/dot_prod_vec_loader.sv
// dot_prod_vec_loader: gathers streamed I/Q samples into dot_length-wide packed vectors.
// Define DOT_PROD_VEC_SLIDE_EN for sliding-window mode (otherwise non-overlapping blocks).
module dot_prod_vec_loader #(
    parameter int i_bits     = 12,
    parameter int q_bits     = 12,
    parameter int dot_length = 5
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clr,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    input  logic [i_bits-1:0]                s_axis_i,
    input  logic [q_bits-1:0]                s_axis_q,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic [i_bits*dot_length-1:0]     m_axis_i,
    output logic [q_bits*dot_length-1:0]     m_axis_q,
    output logic [$clog2(dot_length+1)-1:0]  fill_level
);
    localparam int fw = $clog2(dot_length+1);
    localparam logic [fw-1:0] last = fw'(dot_length-1);
`ifdef DOT_PROD_VEC_SLIDE_EN
    // keep the newest dot_length-1 samples so the next one completes a new window
    localparam logic [fw-1:0] refill = last;
`else
    localparam logic [fw-1:0] refill = '0;
`endif
    typedef enum logic {FILL, FULL} state_t;
    state_t state;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= FILL;
            fill_level    <= '0;
            m_axis_tvalid <= 1'b0;
            s_axis_tready <= 1'b0;
            m_axis_i      <= '0;
            m_axis_q      <= '0;
        end else if (clr) begin
            state         <= FILL;
            fill_level    <= '0;
            m_axis_tvalid <= 1'b0;
            s_axis_tready <= 1'b1;
        end else if (state == FULL) begin
            if (m_axis_tready) begin
                state         <= FILL;
                fill_level    <= refill;
                m_axis_tvalid <= 1'b0;
                s_axis_tready <= 1'b1;
            end
        end else if (s_axis_tvalid && s_axis_tready) begin
            m_axis_i      <= {s_axis_i, m_axis_i[i_bits*dot_length-1:i_bits]};
            m_axis_q      <= {s_axis_q, m_axis_q[q_bits*dot_length-1:q_bits]};
            fill_level    <= fill_level + 1'b1;
            state         <= (fill_level == last) ? FULL : FILL;
            m_axis_tvalid <= (fill_level == last);
            s_axis_tready <= (fill_level != last);
        end else begin
            s_axis_tready <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dot_prod_vec_loader.sv
// tb_dot_prod_vec_loader: directed and random stimulus against a queue-based window model.
module tb_dot_prod_vec_loader;
    localparam int dl = 5;
    logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
    logic s_axis_tvalid = 1'b0, m_axis_tready = 1'b0;
    logic s_axis_tready, m_axis_tvalid;
    logic [11:0] s_axis_i = '0, s_axis_q = '0;
    logic [12*dl-1:0] m_axis_i, m_axis_q;
    logic [2:0] fill_level;
    int total = 0, bad = 0;
    logic [11:0] qi[$], qq[$];
    logic full = 1'b0, rdy = 1'b0, acc = 1'b0;

    dot_prod_vec_loader #(.i_bits(12), .q_bits(12), .dot_length(dl)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_i(s_axis_i), .s_axis_q(s_axis_q),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_i(m_axis_i), .m_axis_q(m_axis_q), .fill_level(fill_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [12*dl-1:0] pack(input logic [11:0] s[$]);
        logic [12*dl-1:0] v = '0;
        for (int k = 0; k < s.size(); k++) v[12*k +: 12] = s[k];
        return v;
    endfunction

    task automatic check_all();
        chk("tvalid", 64'(m_axis_tvalid), 64'(full));
        chk("tready", 64'(s_axis_tready), 64'(rdy));
        chk("fill", 64'(fill_level), 64'(qi.size()));
        if (full) begin
            chk("vec_i", 64'(m_axis_i), 64'(pack(qi)));
            chk("vec_q", 64'(m_axis_q), 64'(pack(qq)));
        end
    endtask

    // one clock: drive, let the edge happen, advance the model, check at negedge
    task automatic step(input logic v, input logic [11:0] i, input logic [11:0] q,
                        input logic mr, input logic c);
        s_axis_tvalid = v; s_axis_i = i; s_axis_q = q; m_axis_tready = mr; clr = c;
        @(posedge clk);
        acc = 1'b0;
        if (c) begin
            qi.delete(); qq.delete(); full = 1'b0; rdy = 1'b1;
        end else if (full) begin
            if (mr) begin
`ifdef DOT_PROD_VEC_SLIDE_EN
                void'(qi.pop_front()); void'(qq.pop_front());
`else
                qi.delete(); qq.delete();
`endif
                full = 1'b0; rdy = 1'b1;
            end
        end else if (v && rdy) begin
            acc = 1'b1;
            qi.push_back(i); qq.push_back(q);
            full = (qi.size() == dl);
            rdy = !full;
        end else begin
            rdy = 1'b1;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic send(input logic [11:0] i, input logic [11:0] q, input logic mr);
        int n = 0;
        do begin
            step(1'b1, i, q, mr, 1'b0);
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("send_timeout", 64'(acc), 64'(1));
    endtask

    initial begin
        #12;
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("rst_tready", 64'(s_axis_tready), 64'(0));
        chk("rst_fill", 64'(fill_level), 64'(0));
        chk("rst_data", 64'(m_axis_i), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 12'd0, 12'd0, 1'b1, 1'b0);
        // continuous I=1..5, Q=-1..-5
        for (int k = 1; k <= 5; k++) step(1'b1, 12'(k), 12'(-k), 1'b1, 1'b0);
        chk("t1_valid", 64'(m_axis_tvalid), 64'(1));
        chk("t1_slot0_i", 64'(m_axis_i[11:0]), 64'(1));
        chk("t1_slot4_i", 64'(m_axis_i[59:48]), 64'(5));
        chk("t1_slot0_q", 64'(m_axis_q[11:0]), 64'h fff);
        step(1'b0, 12'd0, 12'd0, 1'b1, 1'b0);
        // backpressure hold
        step(1'b0, 12'd0, 12'd0, 1'b0, 1'b1);
        for (int k = 1; k <= 5; k++) send(12'(40 + k), 12'(k), 1'b0);
        for (int k = 0; k < 10; k++) step(1'b1, 12'(100 + k), 12'd7, 1'b0, 1'b0);
        chk("t2_slot0_i", 64'(m_axis_i[11:0]), 64'(41));
        step(1'b0, 12'd0, 12'd0, 1'b1, 1'b0);
        // clear mid-vector
        step(1'b0, 12'd0, 12'd0, 1'b0, 1'b1);
        for (int k = 1; k <= 3; k++) send(12'(k), 12'(k), 1'b0);
        step(1'b1, 12'd99, 12'd99, 1'b0, 1'b1);
        chk("t3_fill_clr", 64'(fill_level), 64'(0));
        for (int k = 10; k <= 14; k++) send(12'(k), 12'(k), 1'b0);
        chk("t3_slot0_i", 64'(m_axis_i[11:0]), 64'(10));
        step(1'b0, 12'd0, 12'd0, 1'b1, 1'b0);
        // samples 1..7 with consumer always ready
        step(1'b0, 12'd0, 12'd0, 1'b1, 1'b1);
        for (int k = 1; k <= 7; k++) send(12'(k), 12'(k), 1'b1);
`ifdef DOT_PROD_VEC_SLIDE_EN
        chk("t4_slide_valid", 64'(m_axis_tvalid), 64'(1));
        chk("t4_slide_slot0", 64'(m_axis_i[11:0]), 64'(3));
`else
        chk("t4_block_fill", 64'(fill_level), 64'(2));
`endif
        // asynchronous reset while FULL
        step(1'b0, 12'd0, 12'd0, 1'b0, 1'b1);
        for (int k = 1; k <= 5; k++) send(12'(k), 12'(k), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        qi.delete(); qq.delete(); full = 1'b0; rdy = 1'b0;
        chk("t5_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("t5_data", 64'(m_axis_i), 64'(0));
        chk("t5_fill", 64'(fill_level), 64'(0));
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 12'd0, 12'd0, 1'b0, 1'b0);
        // valid toggling every cycle
        for (int k = 0; k < 10; k++) step(1'(k % 2), 12'(30 + k), 12'(k), 1'b0, 1'b0);
        chk("t6_slot0_i", 64'(m_axis_i[11:0]), 64'(31));
        step(1'b0, 12'd0, 12'd0, 1'b1, 1'b0);
        // random traffic
        for (int k = 0; k < 2000; k++)
            step(1'($urandom_range(0, 3) != 0), 12'($urandom), 12'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
